// File: rtl/pulse_pair_gen.sv
// rtl/pulse_pair_gen.sv - race-logic encoder: two spike times to one-cycle pulses per gamma window
//
// Purpose:
//   Converts two binary spike times into single-cycle x/y pulse events inside a
//   gamma window of GAMMA_LEN cycles. A time that is invalid or >= GAMMA_LEN is
//   "infinity" and produces no pulse. gamma_done marks the window boundary so the
//   downstream comparator can be cleared between windows.
//
// Ports:
//   clk         in   1   clock
//   rst_b       in   1   asynchronous active-low reset
//   start       in   1   request a window; sampled only in IDLE or DONE
//   x_time      in   WL  spike time for x, sampled with start
//   x_valid     in   1   1 = x_time finite, 0 = infinity
//   y_time      in   WL  spike time for y, sampled with start
//   y_valid     in   1   1 = y_time finite, 0 = infinity
//   x_pulse     out  1   one-cycle x spike (registered)
//   y_pulse     out  1   one-cycle y spike (registered)
//   busy        out  1   high in every RUN cycle
//   gamma_done  out  1   one-cycle pulse in the DONE cycle after the final count
//   cnt         out  WL  current window cycle count

module pulse_pair_gen #(
    parameter int WL        = 3,
    parameter int GAMMA_LEN = 8
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          start,
    input  logic [WL-1:0] x_time,
    input  logic          x_valid,
    input  logic [WL-1:0] y_time,
    input  logic          y_valid,
    output logic          x_pulse,
    output logic          y_pulse,
    output logic          busy,
    output logic          gamma_done,
    output logic [WL-1:0] cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Window length held one bit wider than cnt so GAMMA_LEN == 2**WL is representable.
    localparam logic [WL:0]   C_GAMMA = (WL+1)'(GAMMA_LEN);
    localparam logic [WL-1:0] C_LAST  = WL'(GAMMA_LEN - 1);

    state_t        r_state;
    logic [WL-1:0] r_x_time;
    logic [WL-1:0] r_y_time;
    // Latched "finite" flags: valid AND inside the window, so infinity is resolved
    // once at sampling time and never re-evaluated mid-window.
    logic          r_x_valid;
    logic          r_y_valid;

    logic [WL-1:0] w_cnt_inc;
    logic          w_x_fin_in;
    logic          w_y_fin_in;
    logic          w_last;

    assign w_cnt_inc  = cnt + WL'(1);
    assign w_x_fin_in = x_valid && ({1'b0, x_time} < C_GAMMA);
    assign w_y_fin_in = y_valid && ({1'b0, y_time} < C_GAMMA);
    assign w_last     = (cnt == C_LAST);

    // Pulses are registered one cycle ahead of the count they belong to, so that
    // x_pulse is high exactly in the RUN cycle where cnt == x_time. A time of 0 is
    // therefore decided on the sampling edge itself, using the raw inputs.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state    <= IDLE;
            cnt        <= '0;
            x_pulse    <= 1'b0;
            y_pulse    <= 1'b0;
            busy       <= 1'b0;
            gamma_done <= 1'b0;
            r_x_time   <= '0;
            r_y_time   <= '0;
            r_x_valid  <= 1'b0;
            r_y_valid  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    gamma_done <= 1'b0;
                    cnt        <= '0;
                    if (start) begin
                        r_state   <= RUN;
                        busy      <= 1'b1;
                        r_x_time  <= x_time;
                        r_y_time  <= y_time;
                        r_x_valid <= w_x_fin_in;
                        r_y_valid <= w_y_fin_in;
                        x_pulse   <= w_x_fin_in && (x_time == '0);
                        y_pulse   <= w_y_fin_in && (y_time == '0);
                    end else begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                        x_pulse <= 1'b0;
                        y_pulse <= 1'b0;
                    end
                end

                RUN: begin
                    if (w_last) begin
                        r_state    <= DONE;
                        cnt        <= '0;
                        busy       <= 1'b0;
                        gamma_done <= 1'b1;
                        x_pulse    <= 1'b0;
                        y_pulse    <= 1'b0;
                    end else begin
                        cnt     <= w_cnt_inc;
                        x_pulse <= r_x_valid && (r_x_time == w_cnt_inc);
                        y_pulse <= r_y_valid && (r_y_time == w_cnt_inc);
                    end
                end

                default: begin
                    r_state    <= IDLE;
                    cnt        <= '0;
                    busy       <= 1'b0;
                    gamma_done <= 1'b0;
                    x_pulse    <= 1'b0;
                    y_pulse    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_pair_gen.sv
// tb/tb_pulse_pair_gen.sv - self-checking bench for pulse_pair_gen

module tb_pulse_pair_gen;

    localparam int WL = 4;
    localparam int G  = 8;

    logic          clk;
    logic          rst_b;
    logic          start;
    logic [WL-1:0] x_time;
    logic          x_valid;
    logic [WL-1:0] y_time;
    logic          y_valid;
    logic          x_pulse;
    logic          y_pulse;
    logic          busy;
    logic          gamma_done;
    logic [WL-1:0] cnt;

    int errors = 0;
    int checks = 0;

    pulse_pair_gen #(.WL(WL), .GAMMA_LEN(G)) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .start      (start),
        .x_time     (x_time),
        .x_valid    (x_valid),
        .y_time     (y_time),
        .y_valid    (y_valid),
        .x_pulse    (x_pulse),
        .y_pulse    (y_pulse),
        .busy       (busy),
        .gamma_done (gamma_done),
        .cnt        (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a window starts on edge E; edge offset d = n - E gives the window
    // cycle. d < G is RUN with cnt = d, d == G is the DONE cycle, and a new start
    // can only be taken on an edge with d >= G + 1.
    int n      = 0;
    int e_edge = 0;
    bit active = 0;
    bit m_xf, m_yf;
    int m_xt, m_yt;

    initial begin
        int d;
        int e_x, e_y, e_b, e_g, e_c;
        forever begin
            @(posedge clk);
            if (rst_b) begin
                n++;
                if (start && (!active || (n - e_edge) >= G + 1)) begin
                    active = 1;
                    e_edge = n;
                    m_xt   = int'(x_time);
                    m_yt   = int'(y_time);
                    m_xf   = x_valid && (m_xt < G);
                    m_yf   = y_valid && (m_yt < G);
                end
            end
            @(negedge clk);
            if (!rst_b) active = 0;
            e_x = 0; e_y = 0; e_b = 0; e_g = 0; e_c = 0;
            if (active) begin
                d = n - e_edge;
                if (d < G) begin
                    e_b = 1;
                    e_c = d;
                    e_x = (m_xf && m_xt == d) ? 1 : 0;
                    e_y = (m_yf && m_yt == d) ? 1 : 0;
                end else if (d == G) begin
                    e_g = 1;
                end
            end
            chk("x_pulse", int'(x_pulse), e_x);
            chk("y_pulse", int'(y_pulse), e_y);
            chk("busy", int'(busy), e_b);
            chk("gamma_done", int'(gamma_done), e_g);
            chk("cnt", int'(cnt), e_c);
        end
    end

    // One window: returns offsets (cycles after the sampling edge) of the x/y
    // pulses and gamma_done, plus the number of busy cycles; -1 means never seen.
    task automatic run_win(input int xt, input bit xv, input int yt, input bit yv,
                           output int xo, output int yo, output int nb, output int go,
                           output int nx);
        xo = -1; yo = -1; nb = 0; go = -1; nx = 0;
        @(posedge clk); #1;
        start = 1; x_time = WL'(xt); x_valid = xv; y_time = WL'(yt); y_valid = yv;
        @(posedge clk); #1;
        start = 0;
        for (int k = 0; k < G + 2; k++) begin
            @(negedge clk);
            if (x_pulse) begin if (xo < 0) xo = k; nx++; end
            if (y_pulse && yo < 0) yo = k;
            if (busy) nb++;
            if (gamma_done && go < 0) go = k;
            // Input changes after sampling must have no effect.
            x_time = WL'($urandom_range(0, 15)); y_time = WL'($urandom_range(0, 15));
            x_valid = 1'($urandom); y_valid = 1'($urandom);
        end
    endtask

    initial begin
        int xo, yo, nb, go, nx, ng;
        rst_b = 0; start = 0; x_time = '0; x_valid = 0; y_time = '0; y_valid = 0;
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_cnt", int'(cnt), 0);
        repeat (2) @(negedge clk);
        #2 rst_b = 1;
        repeat (3) @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        // Basic window.
        run_win(2, 1, 5, 1, xo, yo, nb, go, nx);
        chk("w1_x_off", xo, 2);
        chk("w1_y_off", yo, 5);
        chk("w1_busy_n", nb, 8);
        chk("w1_done_off", go, 8);
        chk("w1_x_count", nx, 1);

        // Equal times.
        run_win(4, 1, 4, 1, xo, yo, nb, go, nx);
        chk("w2_x_off", xo, 4);
        chk("w2_y_off", yo, 4);

        // Infinity: invalid x, then out-of-range x.
        run_win(3, 0, 1, 1, xo, yo, nb, go, nx);
        chk("w3_x_inf", xo, -1);
        chk("w3_y_off", yo, 1);
        run_win(9, 1, 1, 1, xo, yo, nb, go, nx);
        chk("w4_x_inf", xo, -1);
        run_win(8, 1, 0, 1, xo, yo, nb, go, nx);
        chk("w5_x_eq_g", xo, -1);
        chk("w5_y_zero", yo, 0);

        // Boundary: last in-window time.
        run_win(7, 1, 6, 1, xo, yo, nb, go, nx);
        chk("w6_x_last", xo, 7);
        chk("w6_y_off", yo, 6);

        // start held high, inputs changing every cycle: windows back-to-back.
        ng = 0;
        @(posedge clk); #1;
        start = 1; x_time = 4'd1; x_valid = 1; y_time = 4'd3; y_valid = 1;
        @(posedge clk); #1;
        for (int k = 0; k < 3 * (G + 1); k++) begin
            @(negedge clk);
            if (gamma_done) ng++;
            x_time = WL'($urandom_range(0, 15)); y_time = WL'($urandom_range(0, 7));
            x_valid = 1'($urandom); y_valid = 1;
        end
        chk("b2b_done_count", ng, 3);
        #1 start = 0;
        repeat (G + 3) @(negedge clk);

        // Reset mid-window at cnt == 3.
        @(posedge clk); #1;
        start = 1; x_time = 4'd7; x_valid = 0; y_time = 4'd6; y_valid = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (4) @(negedge clk);
        chk("pre_rst_cnt", int'(cnt), 3);
        #1 rst_b = 0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_cnt", int'(cnt), 0);
        chk("rst_y", int'(y_pulse), 0);
        @(negedge clk); #2 rst_b = 1;
        ng = 0;
        for (int k = 0; k < G + 2; k++) begin
            @(negedge clk);
            if (y_pulse || gamma_done) ng++;
        end
        chk("post_rst_quiet", ng, 0);
        run_win(0, 1, 6, 1, xo, yo, nb, go, nx);
        chk("w7_x_zero", xo, 0);
        chk("w7_y_off", yo, 6);
        chk("w7_done_off", go, 8);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
